// File: rtl/mem_burst_arbiter_if.sv
// Bus bundle shared by the two cache requesters, the burst arbiter and main memory.
// slave is the arbiter's view; master is the cache/memory environment driving it.
interface mem_burst_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_rw;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic [1:0]        m0_beat;
    logic              m0_rvalid;
    logic              m0_done;

    logic              m1_req;
    logic              m1_rw;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic [1:0]        m1_beat;
    logic              m1_rvalid;
    logic              m1_done;

    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_rw, m0_addr, m0_wdata,
        input  m1_req, m1_rw, m1_addr, m1_wdata,
        input  mem_done, mem_rdata,
        output m0_gnt, m0_beat, m0_rvalid, m0_done,
        output m1_gnt, m1_beat, m1_rvalid, m1_done,
        output rdata, mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_rw, m0_addr, m0_wdata,
        output m1_req, m1_rw, m1_addr, m1_wdata,
        output mem_done, mem_rdata,
        input  m0_gnt, m0_beat, m0_rvalid, m0_done,
        input  m1_gnt, m1_beat, m1_rvalid, m1_done,
        input  rdata, mem_en, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Shares one memory port between the D-cache (port 0) and I-cache (port 1) as 4-word bursts.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_burst_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_burst_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BURST  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]        state;
    logic              winner;
    logic              burst_rw;
    logic [ADDR_W-5:0] base_hi;
    logic [1:0]        beat;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    logic              any_req;
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic              in_burst;
    logic              beat_done;
    logic              gnt0;
    logic              gnt1;

    assign any_req   = bus.m0_req | bus.m1_req;
    assign pick_addr = pick ? bus.m1_addr : bus.m0_addr;
    assign in_burst  = (state == BURST);
    assign beat_done = in_burst & bus.mem_done;

`ifdef MEM_ARB_RR_EN
    logic last_winner;

    // On a tie the port that did not win last time gets the bus.
    assign pick = (bus.m0_req & bus.m1_req) ? ~last_winner : bus.m1_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_winner <= pick;
        end
    end
`else
    assign pick = ~bus.m0_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            winner   <= 1'b0;
            burst_rw <= 1'b0;
            base_hi  <= '0;
            beat     <= 2'd0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            rvalid <= beat_done & ~burst_rw;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner   <= pick;
                        burst_rw <= pick ? bus.m1_rw : bus.m0_rw;
                        base_hi  <= pick_addr[ADDR_W-1:4];
                        beat     <= 2'd0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (bus.mem_done) begin
                        // Beat 3 completing also leaves BURST, so the counter is back at 0 for the next grant.
                        beat <= beat + 2'd1;
                        if (!burst_rw) begin
                            rdata <= bus.mem_rdata;
                        end
                        if (beat == 2'd3) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt0 = in_burst & ~winner;
    assign gnt1 = in_burst & winner;

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_beat   = gnt0 ? beat : 2'd0;
    assign bus.m1_beat   = gnt1 ? beat : 2'd0;
    assign bus.m0_rvalid = rvalid & ~winner;
    assign bus.m1_rvalid = rvalid & winner;
    assign bus.m0_done   = (state == FINISH) & ~winner;
    assign bus.m1_done   = (state == FINISH) & winner;
    assign bus.rdata     = rdata;

    // The base has its low nibble cleared, so base + 4*beat is a plain concatenation.
    assign bus.mem_en    = in_burst;
    assign bus.mem_rw    = in_burst & burst_rw;
    assign bus.mem_addr  = in_burst ? {base_hi, beat, 2'b00} : '0;
    assign bus.mem_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: directed scenarios plus random burst rounds,
// checked against a transaction-level model of arbitration order and burst contents.
module tb_mem_burst_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic                   rw;
        logic [ADDR_W-1:0]      addr;
        logic [3:0][DATA_W-1:0] wd;
    } burst_t;

    typedef struct packed {
        logic              port;
        logic [1:0]        beat;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mem_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    burst_t pq0[$];
    burst_t pq1[$];
    burst_t st0[$];
    burst_t st1[$];
    acc_t   exp_acc[$];
    rd_t    exp_rd[$];
    logic   exp_done[$];

    int   tests = 0;
    int   fails = 0;
    int   mem_mode = 3;
    int   stall_cnt = 0;
    int   hold = 0;
    logic force_low0 = 1'b0;
    logic model_last = 1'b1;
    logic prev_rd = 1'b0;
    logic prev_last = 1'b0;
    logic prev_en = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    // Memory contents are a fixed scramble of the word address.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, 22'h0} ^ (32'h1357_9BDF + {22'h0, a} * 32'd40503);
    endfunction

    function automatic burst_t mkBurst(input logic rw, input logic [ADDR_W-1:0] addr);
        burst_t b;
        b.rw   = rw;
        b.addr = addr;
        for (int k = 0; k < 4; k++) b.wd[k] = $urandom();
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushBurst(input logic port, input burst_t b);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] a;
        base = b.addr & ~ADDR_W'(15);
        for (int k = 0; k < 4; k++) begin
            a = base + ADDR_W'(4 * k);
            exp_acc.push_back('{port: port, beat: 2'(k), rw: b.rw, addr: a, wdata: b.wd[k]});
            if (!b.rw) exp_rd.push_back('{port: port, data: mem_word(a)});
        end
        exp_done.push_back(port);
    endtask

    // Staged bursts all raise req together; the model decides the service order.
    task automatic applyStimulus();
        int   i0 = 0;
        int   i1 = 0;
        logic w;
        while (i0 < st0.size() || i1 < st1.size()) begin
            if (i0 < st0.size() && i1 < st1.size()) begin
`ifdef MEM_ARB_RR_EN
                w = ~model_last;
`else
                w = 1'b0;
`endif
            end else begin
                w = (i1 < st1.size());
            end
            model_last = w;
            if (!w) begin
                pushBurst(1'b0, st0[i0]);
                i0++;
            end else begin
                pushBurst(1'b1, st1[i1]);
                i1++;
            end
        end
        foreach (st0[i]) pq0.push_back(st0[i]);
        foreach (st1[i]) pq1.push_back(st1[i]);
        st0.delete();
        st1.delete();
    endtask

    task automatic flushAll();
        exp_acc.delete();
        exp_rd.delete();
        exp_done.delete();
        pq0.delete();
        pq1.delete();
        prev_rd    = 1'b0;
        prev_last  = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        flushAll();
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while ((exp_done.size() + exp_acc.size() + exp_rd.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput({tag, "_pending"}, 64'(exp_done.size() + exp_acc.size() + exp_rd.size()), 0);
        if ((exp_done.size() + exp_acc.size() + exp_rd.size()) != 0) doReset();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_gnt"}, {bus.m1_gnt, bus.m0_gnt}, 0);
        checkOutput({tag, "_beat"}, {bus.m1_beat, bus.m0_beat}, 0);
        checkOutput({tag, "_rvalid"}, {bus.m1_rvalid, bus.m0_rvalid}, 0);
        checkOutput({tag, "_done"}, {bus.m1_done, bus.m0_done}, 0);
        checkOutput({tag, "_rdata"}, bus.rdata, 0);
        checkOutput({tag, "_mem_en"}, bus.mem_en, 0);
        checkOutput({tag, "_mem_rw"}, bus.mem_rw, 0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
    endtask

    // Requesters and memory drive their inputs shortly after each rising edge.
    initial begin
        bus.m0_req = 1'b0; bus.m0_rw = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_rw = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_done = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.m0_req = (pq0.size() != 0) && !force_low0;
            if (pq0.size() != 0) begin
                bus.m0_rw    = pq0[0].rw;
                bus.m0_addr  = pq0[0].addr;
                bus.m0_wdata = pq0[0].wd[bus.m0_beat];
            end
            bus.m1_req = (pq1.size() != 0);
            if (pq1.size() != 0) begin
                bus.m1_rw    = pq1[0].rw;
                bus.m1_addr  = pq1[0].addr;
                bus.m1_wdata = pq1[0].wd[bus.m1_beat];
            end
            case (mem_mode)
                0: bus.mem_done = ($urandom_range(0, 2) != 0);
                1: bus.mem_done = 1'b1;
                2: begin
                    if (!bus.mem_en) stall_cnt = 0;
                    else stall_cnt++;
                    bus.mem_done = (stall_cnt == 3);
                    if (stall_cnt == 3) stall_cnt = 0;
                end
                default: bus.mem_done = 1'b0;
            endcase
            bus.mem_rdata = bus.mem_done ? mem_word(bus.mem_addr) : $urandom();
        end
    end

    task automatic monitorCycle();
        logic rv_any;
        logic dn_any;
        logic rd_now;
        logic last_now;
        acc_t e;
        rd_t  r;
        logic p;
        rv_any   = bus.m0_rvalid | bus.m1_rvalid;
        dn_any   = bus.m0_done | bus.m1_done;
        rd_now   = 1'b0;
        last_now = 1'b0;
        if (bus.mem_en) begin
            hold = (prev_en && bus.mem_addr == prev_addr) ? hold + 1 : 1;
            if (exp_acc.size() == 0) begin
                checkOutput("idle_mem_en", bus.mem_en, 0);
            end else begin
                e = exp_acc[0];
                checkOutput("mem_addr", bus.mem_addr, e.addr);
                checkOutput("mem_rw", bus.mem_rw, e.rw);
                checkOutput("gnt", {bus.m1_gnt, bus.m0_gnt}, e.port ? 2'b10 : 2'b01);
                checkOutput("beat", e.port ? bus.m1_beat : bus.m0_beat, e.beat);
                if (e.rw) checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
                if (bus.mem_done) begin
                    e = exp_acc.pop_front();
                    if (mem_mode == 2) checkOutput("addr_hold_cycles", 64'(hold), 3);
                    rd_now   = !e.rw;
                    last_now = (e.beat == 2'd3);
                end
            end
        end
        if (prev_rd || rv_any) checkOutput("rvalid_timing", rv_any, prev_rd);
        if (rv_any) begin
            if (exp_rd.size() == 0) begin
                checkOutput("stray_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 0);
            end else begin
                r = exp_rd.pop_front();
                checkOutput("rvalid_port", {bus.m1_rvalid, bus.m0_rvalid}, r.port ? 2'b10 : 2'b01);
                checkOutput("rdata", bus.rdata, r.data);
            end
        end
        if (prev_last || dn_any) checkOutput("done_timing", dn_any, prev_last);
        if (dn_any) begin
            checkOutput("gnt_in_finish", {bus.m1_gnt, bus.m0_gnt}, 0);
            if (exp_done.size() == 0) begin
                checkOutput("stray_done", {bus.m1_done, bus.m0_done}, 0);
            end else begin
                p = exp_done.pop_front();
                checkOutput("done_port", {bus.m1_done, bus.m0_done}, p ? 2'b10 : 2'b01);
                if (p && pq1.size() != 0) void'(pq1.pop_front());
                if (!p && pq0.size() != 0) void'(pq0.pop_front());
            end
        end
        prev_rd   = rd_now;
        prev_last = last_now;
        prev_en   = bus.mem_en;
        prev_addr = bus.mem_addr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) monitorCycle();
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [ADDR_W-1:0] a;

        reset = 1'b1;
        mem_mode = 3;
        repeat (3) @(posedge clk);
        #1;
        checkReset("por");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single read, memory always ready: exact cycle-by-cycle timing.
        mem_mode = 1;
        st0.push_back(mkBurst(1'b0, 10'h2B7));
        applyStimulus();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_mem_en_c%0d", c), bus.mem_en, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) checkOutput($sformatf("t1_addr_c%0d", c), bus.mem_addr, 64'(10'h2B0 + 4 * (c - 1)));
            checkOutput($sformatf("t1_done_c%0d", c), bus.m0_done, (c == 5));
            checkOutput($sformatf("t1_rvalid_c%0d", c), bus.m0_rvalid, (c >= 2 && c <= 5));
        end
        @(posedge clk);
        #1;
        waitDrain("single_read", 20);

        // Held request on port 1 re-grants after exactly two idle cycles of mem_en.
        st1.push_back(mkBurst(1'b0, 10'h123));
        st1.push_back(mkBurst(1'b1, 10'h3F9));
        applyStimulus();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 1) checkOutput($sformatf("b2b_mem_en_c%0d", c), bus.mem_en, (c <= 4 || c >= 7));
        end
        @(posedge clk);
        #1;
        waitDrain("back_to_back", 40);

        // Stalled write: every address held for three cycles.
        mem_mode = 2;
        st1.push_back(mkBurst(1'b1, 10'h040));
        applyStimulus();
        waitDrain("stall_write", 40);

        // Continuous tie between both ports.
        mem_mode = 0;
        st0.push_back(mkBurst(1'b0, 10'h100));
        st0.push_back(mkBurst(1'b1, 10'h110));
        st1.push_back(mkBurst(1'b0, 10'h200));
        st1.push_back(mkBurst(1'b0, 10'h210));
        applyStimulus();
        waitDrain("tie", 300);

        // Request dropped at beat 1 still completes.
        mem_mode = 2;
        st0.push_back(mkBurst(1'b0, 10'h08C));
        applyStimulus();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.m0_beat != 2'd1 && n < 40);
        checkOutput("drop_reach_beat1", bus.m0_beat, 1);
        @(posedge clk);
        #1;
        force_low0 = 1'b1;
        waitDrain("req_drop", 40);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("drop_no_regrant", bus.mem_en, 0);
        end
        @(posedge clk);
        #1;
        force_low0 = 1'b0;

        // Reset at beat 2 drops the burst; afterwards a tie goes to port 0.
        mem_mode = 1;
        st0.push_back(mkBurst(1'b0, 10'h2F0));
        applyStimulus();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_at_beat2", bus.m0_beat, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        flushAll();
        checkReset("mid_reset");
        @(negedge clk);
        checkOutput("mid_reset_no_done", {bus.m1_done, bus.m0_done}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        mem_mode = 0;
        st0.push_back(mkBurst(1'b1, 10'h050));
        st1.push_back(mkBurst(1'b0, 10'h060));
        applyStimulus();
        waitDrain("post_reset_tie", 200);

        // Spurious mem_done while idle.
        mem_mode = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("spurious_mem_en", bus.mem_en, 0);
            checkOutput("spurious_outputs", {bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done, bus.m1_rvalid, bus.m0_rvalid}, 0);
        end
        @(posedge clk);
        #1;

        // Random rounds.
        for (int r = 0; r < 30; r++) begin
            int mask;
            mask = $urandom_range(1, 3);
            mem_mode = $urandom_range(0, 2);
            if (mask[0]) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                    a = ADDR_W'($urandom());
                    if ($urandom_range(0, 3) == 0) a[ADDR_W-1:4] = '1;
                    st0.push_back(mkBurst(1'($urandom()), a));
                end
            end
            if (mask[1]) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
                    a = ADDR_W'($urandom());
                    st1.push_back(mkBurst(1'($urandom()), a));
                end
            end
            applyStimulus();
            waitDrain($sformatf("random_%0d", r), 300);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
